// File: rtl/mips_prog_loader.sv
// Boot loader for mips_32: streams words into instruction memory while the core is held,
// then loads the PC and releases the core. Optional checksum gate: define CHECKSUM_EN.
module mips_prog_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] expected_sum,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              pc_init_we,
    output logic [DATA_W-1:0] pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_RELEASE, ST_DONE, ST_ERROR} state_e;
    localparam state_e LOAD_EXIT = ST_CHECK;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RELEASE, ST_DONE} state_e;
    localparam state_e LOAD_EXIT = ST_RELEASE;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                s_ready_q, s_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                pc_init_we_q, pc_init_we_d;
    logic [DATA_W-1:0]   pc_init_q, pc_init_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                can_start_c;
    logic                accept_c;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
`else
    logic                unused_expected_sum_c;
    assign unused_expected_sum_c = ^expected_sum;
`endif

    assign accept_c = s_valid && s_ready_q;

    // A new session may only be opened from a resting state.
    always_comb begin
        can_start_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef CHECKSUM_EN
        can_start_c = can_start_c || (state_q == ST_ERROR);
`endif
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            pc_init_we_q <= 1'b0;
            pc_init_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            pc_init_we_q <= pc_init_we_d;
            pc_init_q    <= pc_init_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CHECKSUM_EN
            sum_q        <= sum_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next state; every output register is derived from the upcoming state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pc_init_d   = pc_init_q;
`ifdef CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (can_start_c && start) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            pc_init_d   = DATA_W'(base_addr);
`ifdef CHECKSUM_EN
            sum_d       = '0;
`endif
            state_d     = (word_count == '0) ? LOAD_EXIT : ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept_c) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = s_data;
                        addr_d      = addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
`ifdef CHECKSUM_EN
                        sum_d       = sum_q + s_data;
`endif
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = LOAD_EXIT;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                ST_CHECK:   state_d = (sum_q == expected_sum) ? ST_RELEASE : ST_ERROR;
`endif
                ST_RELEASE: state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end

        s_ready_d    = (state_d == ST_LOAD) && (remaining_d != '0);
        cpu_hold_d   = (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        pc_init_we_d = (state_d == ST_RELEASE);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_RELEASE);
`ifdef CHECKSUM_EN
        busy_d       = busy_d || (state_d == ST_CHECK);
        err_d        = (state_d == ST_ERROR);
`endif
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign pc_init_we = pc_init_we_q;
    assign pc_init    = pc_init_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: expected writes/PC loads are queued by the stimulus
// and consumed by a monitor watching mem_we and pc_init_we.
module tb_mips_prog_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
`ifdef CHECKSUM_EN
    localparam int unsigned REL_LAT = 1;
`else
    localparam int unsigned REL_LAT = 0;
`endif

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic [DATA_W-1:0] expected_sum = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready, mem_we, cpu_hold, pc_init_we, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, pc_init;

    mips_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .expected_sum(expected_sum), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .pc_init_we(pc_init_we),
        .pc_init(pc_init), .busy(busy), .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } wr_t;

    wr_t          exp_wr[$];
    logic [31:0]  exp_pc[$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  words [0:15];
    int           gaps  [0:15];

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Monitor: every write and PC load must match the head of its queue.
    always @(negedge clk1) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h", mem_addr, mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (pc_init_we === 1'b1) begin
            if (exp_pc.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pc_init_we pc_init=%0h", pc_init);
            end else begin
                chk("pc_init", pc_init, exp_pc.pop_front());
                chk("writes_before_pc", 32'(exp_wr.size()), 32'd0);
            end
        end
    end

    task automatic load_factorial();
        words[0]  = 32'h280a00c8; words[1] = 32'h28020001; words[2]  = 32'h0e94a000;
        words[3]  = 32'h21430000; words[4] = 32'h0e94a000; words[5]  = 32'h14431000;
        words[6]  = 32'h2c630001; words[7] = 32'h0e94a000; words[8]  = 32'h3460fffc;
        words[9]  = 32'h2542fffe; words[10] = 32'hfc000000;
    endtask

    task automatic run_session(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                               input bit use_gaps, input bit hold_valid, input bit exp_ok,
                               input string tag, output int unsigned first_acc,
                               output int unsigned last_acc);
        logic [31:0] sum;
        bit          acc;
        int          budget;
        int unsigned waited;
        sum = '0;
        first_acc = 0;
        last_acc = 0;
        for (int i = 0; i < int'(cnt); i++) sum = sum + words[i];
        expected_sum = exp_ok ? sum : sum + 32'd1;
        if (exp_ok) exp_pc.push_back(32'(base));
        base_addr = base;
        word_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_hold_at_start"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done_at_start"}, 32'(done), 32'd0);
        for (int i = 0; i < int'(cnt); i++) begin
            if (use_gaps) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    s_valid = 1'b0;
                    s_data = $urandom;
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data = words[i];
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 50) begin
                acc = (s_ready === 1'b1);
                tick();
                budget++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL %s_accept_timeout beat=%0d", tag, i);
                s_valid = 1'b0;
                return;
            end
            exp_wr.push_back('{addr: ADDR_W'(32'(base) + 32'(i)), data: words[i], cyc: cyc});
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            if (hold_valid) s_data = $urandom;
            else s_valid = 1'b0;
        end
        waited = 0;
        while (pc_init_we !== 1'b1 && waited < 6) begin
            tick();
            waited++;
        end
        s_valid = 1'b0;
        if (exp_ok) begin
            chk({tag, "_release_latency"}, waited, REL_LAT);
            tick();
            chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'd0);
        end else begin
            chk({tag, "_err"}, 32'(err), 32'd1);
            chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
            chk({tag, "_done"}, 32'(done), 32'd0);
            chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        end
    endtask

    initial begin
        int unsigned f, l;
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pc_init", pc_init, 32'd0);
        chk("rst_pc_init_we", 32'(pc_init_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: factorial, s_valid held high, beats back to back
        load_factorial();
        run_session(10'd0, 11'd11, 1'b0, 1'b1, 1'b1, "t1", f, l);
        chk("t1_consecutive", l - f, 32'd10);

        // 2: same load from DONE with gaps; stray s_valid afterwards must not write
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1; gaps[4] = 3; gaps[5] = 0;
        gaps[6] = 0; gaps[7] = 2; gaps[8] = 1; gaps[9] = 0; gaps[10] = 4;
        run_session(10'd0, 11'd11, 1'b1, 1'b0, 1'b1, "t2", f, l);
        s_valid = 1'b1;
        s_data = 32'hdeadbeef;
        tick(); tick(); tick();
        s_valid = 1'b0;

        // 3: address wrap 1020..1023,0..3
        for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h11;
        run_session(10'd1020, 11'd8, 1'b0, 1'b0, 1'b1, "t3", f, l);

        // 4: empty load
        run_session(10'd37, 11'd0, 1'b0, 1'b0, 1'b1, "t4", f, l);

        // 5: reset mid-load; start during LOAD ignored
        load_factorial();
        base_addr = 10'd0;
        word_count = 11'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                s_valid = 1'b0;
                base_addr = 10'd500;
                word_count = 11'd3;
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("t5_busy_after_start", 32'(busy), 32'd1);
                chk("t5_ready_after_start", 32'(s_ready), 32'd1);
                s_valid = 1'b1;
            end
            s_data = words[i];
            chk("t5_ready", 32'(s_ready), 32'd1);
            tick();
            exp_wr.push_back('{addr: ADDR_W'(i), data: words[i], cyc: cyc});
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_pending_writes", 32'(exp_wr.size()), 32'd0);
        tick(); tick();
        chk("t5_no_pc_we", 32'(pc_init_we), 32'd0);
        chk("t5_idle_hold", 32'(cpu_hold), 32'd1);

`ifdef CHECKSUM_EN
        // 6: wrong checksum parks in ERROR, correct one releases
        run_session(10'd0, 11'd11, 1'b0, 1'b0, 1'b0, "t6_bad", f, l);
        tick(); tick();
        chk("t6_stays_err", 32'(err), 32'd1);
        run_session(10'd0, 11'd11, 1'b0, 1'b0, 1'b1, "t6_good", f, l);
`endif

        tick(); tick();
        chk("final_wr_queue", 32'(exp_wr.size()), 32'd0);
        chk("final_pc_queue", 32'(exp_pc.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
